// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the MIPS pipeline and its hazard/forwarding controller.
// The pipeline side drives the ID/EX status fields; the controller drives holds, flushes, selects and counters.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW     = 5,
   parameter int FWD_STAGES = 2,
   parameter int CNT_W      = 16
);
   localparam int SEL_W = $clog2(FWD_STAGES + 1);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] id_dst;
   logic              id_regwrite;
   logic              id_memread;
   logic              ex_branch_taken;
   logic              pc_hold;
   logic              ifid_hold;
   logic              id_bubble;
   logic              flush_ifid;
   logic [SEL_W-1:0]  fwd_sel_a;
   logic [SEL_W-1:0]  fwd_sel_b;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
             id_regwrite, id_memread, ex_branch_taken,
      input  pc_hold, ifid_hold, id_bubble, flush_ifid,
             fwd_sel_a, fwd_sel_b, stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
             id_regwrite, id_memread, ex_branch_taken,
      output pc_hold, ifid_hold, id_bubble, flush_ifid,
             fwd_sel_a, fwd_sel_b, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and flush controller for an in-order MIPS pipeline.
// A private scoreboard shadows EX..last forwarding stage and drives stalls, flushes and operand selects.
module pipeline_hazard_ctrl #(
   parameter int REG_AW     = 5,
   parameter int FWD_STAGES = 2,
   parameter int LOAD_STAGE = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int SEL_W = $clog2(FWD_STAGES + 1);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              use_rs;
      logic              use_rt;
      logic [REG_AW-1:0] dst;
      logic              regwrite;
      logic              load;
   } entry_t;

   entry_t           r_sb [0:FWD_STAGES];
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;

   entry_t           w_ex_next;
   logic             w_load_hit;
   logic             w_stall;
   logic             w_flush;
   logic [SEL_W-1:0] w_fwd_a;
   logic [SEL_W-1:0] w_fwd_b;

   function automatic logic f_match(input entry_t e, input logic [REG_AW-1:0] s);
      return e.valid && e.regwrite && (e.dst == s) && (s != '0);
   endfunction

   // Only loads younger than the stage where their data appears can force a stall.
   always_comb begin
      w_load_hit = 1'b0;
      for (int j = 0; j <= FWD_STAGES; j++) begin
         if ((j < LOAD_STAGE - 1) && r_sb[j].load) begin
            if ((bus.id_use_rs && f_match(r_sb[j], bus.id_rs)) ||
                (bus.id_use_rt && f_match(r_sb[j], bus.id_rt)))
               w_load_hit = 1'b1;
         end
      end
   end

   assign w_flush = bus.ex_branch_taken;
   assign w_stall = bus.id_valid && !w_flush && w_load_hit;

   // Hold/bubble contract: pc_hold and ifid_hold freeze the front end for one
   // cycle while id_bubble injects a NOP into ID/EX; on a flush the front end
   // keeps moving (target fetch) while IF/ID is cleared and ID is bubbled.
   assign bus.pc_hold    = w_stall;
   assign bus.ifid_hold  = w_stall;
   assign bus.id_bubble  = w_stall || w_flush;
   assign bus.flush_ifid = w_flush;

   always_comb begin
      w_ex_next = '0;
      if (bus.id_valid && !w_stall && !w_flush) begin
         w_ex_next.valid    = 1'b1;
         w_ex_next.rs       = bus.id_rs;
         w_ex_next.rt       = bus.id_rt;
         w_ex_next.use_rs   = bus.id_use_rs;
         w_ex_next.use_rt   = bus.id_use_rt;
         w_ex_next.dst      = bus.id_dst;
         w_ex_next.regwrite = bus.id_regwrite;
         w_ex_next.load     = bus.id_memread;
      end
   end

   // Scan oldest to youngest so the youngest eligible producer wins.
   always_comb begin
      w_fwd_a = '0;
      w_fwd_b = '0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (!r_sb[k].load || (k >= LOAD_STAGE)) begin
            if (r_sb[0].valid && r_sb[0].use_rs && f_match(r_sb[k], r_sb[0].rs))
               w_fwd_a = SEL_W'(k);
            if (r_sb[0].valid && r_sb[0].use_rt && f_match(r_sb[k], r_sb[0].rt))
               w_fwd_b = SEL_W'(k);
         end
      end
   end

   assign bus.fwd_sel_a   = w_fwd_a;
   assign bus.fwd_sel_b   = w_fwd_b;
   assign bus.stall_count = r_stall_count;
   assign bus.flush_count = r_flush_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= FWD_STAGES; k++)
            r_sb[k] <= '0;
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         for (int k = 1; k <= FWD_STAGES; k++)
            r_sb[k] <= r_sb[k-1];
         r_sb[0] <= w_ex_next;
         if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
         if (w_flush && (r_flush_count != {CNT_W{1'b1}}))
            r_flush_count <= r_flush_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with 4-bit counters so saturation is reachable.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_pipeline_hazard_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   exp_stall;
   int   exp_flush;

   pipeline_hazard_ctrl_if #(.REG_AW(5), .FWD_STAGES(2), .CNT_W(4)) bus ();

   pipeline_hazard_ctrl #(
      .REG_AW(5), .FWD_STAGES(2), .LOAD_STAGE(2), .CNT_W(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive_id(input logic v, input int rs, input int rt, input logic urs,
                           input logic urt, input int dst, input logic rw, input logic mr);
      bus.id_valid    = v;
      bus.id_rs       = 5'(rs);
      bus.id_rt       = 5'(rt);
      bus.id_use_rs   = urs;
      bus.id_use_rt   = urt;
      bus.id_dst      = 5'(dst);
      bus.id_regwrite = rw;
      bus.id_memread  = mr;
   endtask

   task automatic idle();
      drive_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic flush_pipe();
      idle();
      bus.ex_branch_taken = 1'b0;
      repeat (4) next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.ex_branch_taken = 1'b0;
      drive_id(1'b1, 1, 2, 1'b1, 1'b0, 2, 1'b1, 1'b1);
      next_cycle();
      drive_id(1'b1, 2, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);
      next_cycle();
      #1;
      checks++; if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL reset_pc_hold: got %b expected 0", bus.pc_hold); end
      checks++; if (bus.ifid_hold !== 1'b0) begin errors++; $display("FAIL reset_ifid_hold: got %b expected 0", bus.ifid_hold); end
      checks++; if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL reset_id_bubble: got %b expected 0", bus.id_bubble); end
      checks++; if (bus.flush_ifid !== 1'b0) begin errors++; $display("FAIL reset_flush_ifid: got %b expected 0", bus.flush_ifid); end
      checks++; if (bus.fwd_sel_a !== 2'd0 || bus.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL reset_fwd: got a=%0d b=%0d expected 0/0", bus.fwd_sel_a, bus.fwd_sel_b); end
      checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin errors++; $display("FAIL reset_counts: got s=%0d f=%0d expected 0/0", bus.stall_count, bus.flush_count); end
      bus.ex_branch_taken = 1'b1;
      #1;
      checks++; if (bus.flush_ifid !== 1'b1 || bus.id_bubble !== 1'b1 || bus.pc_hold !== 1'b0) begin errors++; $display("FAIL reset_branch_comb: got flush=%b bubble=%b hold=%b expected 1/1/0", bus.flush_ifid, bus.id_bubble, bus.pc_hold); end
      bus.ex_branch_taken = 1'b0;
      idle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic test_back_to_back();
      drive_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);   // add $3
      next_cycle();
      drive_id(1'b1, 3, 4, 1'b1, 1'b1, 6, 1'b1, 1'b0);   // sub $6,$3,$4
      next_cycle();
      #1;
      checks++; if (bus.fwd_sel_a !== 2'd1) begin errors++; $display("FAIL b2b_fwd_a_mem: got %0d expected 1", bus.fwd_sel_a); end
      checks++; if (bus.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL b2b_fwd_b_none: got %0d expected 0", bus.fwd_sel_b); end
      drive_id(1'b1, 3, 9, 1'b1, 1'b0, 7, 1'b1, 1'b0);   // unrelated, reads $3
      next_cycle();
      #1;
      checks++; if (bus.fwd_sel_a !== 2'd2) begin errors++; $display("FAIL b2b_fwd_a_wb: got %0d expected 2", bus.fwd_sel_a); end
      checks++; if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL b2b_no_stall: got %b expected 0", bus.pc_hold); end
      flush_pipe();
   endtask

   task automatic test_double_producer();
      drive_id(1'b1, 1, 0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
      next_cycle();
      drive_id(1'b1, 1, 0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
      next_cycle();
      drive_id(1'b1, 8, 5, 1'b1, 1'b1, 10, 1'b1, 1'b0);
      next_cycle();
      #1;
      checks++; if (bus.fwd_sel_b !== 2'd1) begin errors++; $display("FAIL double_fwd_b: got %0d expected 1", bus.fwd_sel_b); end
      checks++; if (bus.fwd_sel_a !== 2'd0) begin errors++; $display("FAIL double_fwd_a: got %0d expected 0", bus.fwd_sel_a); end
      flush_pipe();
   endtask

   task automatic test_load_use();
      drive_id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);   // lw $2
      next_cycle();
      drive_id(1'b1, 2, 7, 1'b1, 1'b1, 8, 1'b1, 1'b0);   // add $8,$2,$7
      #1;
      checks++; if ({bus.pc_hold, bus.ifid_hold, bus.id_bubble, bus.flush_ifid} !== 4'b1110) begin errors++; $display("FAIL loaduse_stall: got %b expected 1110", {bus.pc_hold, bus.ifid_hold, bus.id_bubble, bus.flush_ifid}); end
      exp_stall++;
      next_cycle();
      #1;
      checks++; if ({bus.pc_hold, bus.ifid_hold, bus.id_bubble} !== 3'b000) begin errors++; $display("FAIL loaduse_release: got %b expected 000", {bus.pc_hold, bus.ifid_hold, bus.id_bubble}); end
      checks++; if (bus.stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL loaduse_count: got %0d expected %0d", bus.stall_count, exp_stall); end
      next_cycle();
      idle();
      #1;
      checks++; if (bus.fwd_sel_a !== 2'd2) begin errors++; $display("FAIL loaduse_fwd_a: got %0d expected 2", bus.fwd_sel_a); end
      flush_pipe();
   endtask

   task automatic test_flush_beats_stall();
      drive_id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
      next_cycle();
      drive_id(1'b1, 2, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
      bus.ex_branch_taken = 1'b1;
      #1;
      checks++; if ({bus.flush_ifid, bus.id_bubble, bus.pc_hold, bus.ifid_hold} !== 4'b1100) begin errors++; $display("FAIL flush_prio: got %b expected 1100", {bus.flush_ifid, bus.id_bubble, bus.pc_hold, bus.ifid_hold}); end
      exp_flush++;
      next_cycle();
      bus.ex_branch_taken = 1'b0;
      idle();
      #1;
      checks++; if (bus.stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL flush_stall_count: got %0d expected %0d", bus.stall_count, exp_stall); end
      checks++; if (bus.flush_count !== 4'(exp_flush)) begin errors++; $display("FAIL flush_count: got %0d expected %0d", bus.flush_count, exp_flush); end
      flush_pipe();
   endtask

   task automatic test_zero_reg();
      drive_id(1'b1, 1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);   // lw $0
      next_cycle();
      drive_id(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0);   // reads and writes $0
      #1;
      checks++; if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL zero_no_stall: got %b expected 0", bus.pc_hold); end
      next_cycle();
      drive_id(1'b1, 0, 0, 1'b1, 1'b1, 4, 1'b1, 1'b0);
      next_cycle();
      #1;
      checks++; if (bus.fwd_sel_a !== 2'd0 || bus.fwd_sel_b !== 2'd0) begin errors++; $display("FAIL zero_fwd: got a=%0d b=%0d expected 0/0", bus.fwd_sel_a, bus.fwd_sel_b); end
      flush_pipe();
   endtask

   task automatic test_reset_mid_stall();
      drive_id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
      next_cycle();
      drive_id(1'b1, 2, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
      #1;
      checks++; if (bus.pc_hold !== 1'b1) begin errors++; $display("FAIL midrst_pre_stall: got %b expected 1", bus.pc_hold); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({bus.pc_hold, bus.ifid_hold, bus.id_bubble} !== 3'b000) begin errors++; $display("FAIL midrst_holds: got %b expected 000", {bus.pc_hold, bus.ifid_hold, bus.id_bubble}); end
      checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin errors++; $display("FAIL midrst_counts: got s=%0d f=%0d expected 0/0", bus.stall_count, bus.flush_count); end
      exp_stall = 0;
      exp_flush = 0;
      next_cycle();
      rst_n = 1'b1;
      #1;
      checks++; if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL midrst_no_resume: got %b expected 0", bus.pc_hold); end
      next_cycle();
      idle();
      next_cycle();
      #1;
      checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL midrst_count_after: got %0d expected 0", bus.stall_count); end
      flush_pipe();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         drive_id(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
         next_cycle();
         drive_id(1'b1, 2, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
         next_cycle();
         next_cycle();
         exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
         if (i == 9) begin
            #1;
            checks++; if (bus.stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL sat_stall_mid: got %0d expected %0d", bus.stall_count, exp_stall); end
         end
      end
      #1;
      checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_stall: got %0d expected 15", bus.stall_count); end
      idle();
      for (int i = 0; i < 20; i++) begin
         bus.ex_branch_taken = 1'b1;
         next_cycle();
      end
      bus.ex_branch_taken = 1'b0;
      #1;
      checks++; if (bus.flush_count !== 4'd15) begin errors++; $display("FAIL sat_flush: got %0d expected 15", bus.flush_count); end
      checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_stall_hold: got %0d expected 15", bus.stall_count); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_stall = 0;
      exp_flush = 0;
      test_reset();
      test_back_to_back();
      test_double_producer();
      test_load_use();
      test_flush_beats_stall();
      test_zero_reg();
      test_reset_mid_stall();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the in-order MIPS pipeline. It replaces the separate hazard-detection and forwarding units.
- It keeps its own scoreboard of in-flight instructions, from EX down to the last forwardable stage.
- From that scoreboard it generates the PC/IF-ID hold, the ID bubble, the branch flushes and the EX operand-forward selects.
- Forwarding depth and load-data stage are parameters, so deeper pipelines reuse the block unchanged.

Parameters:
- REG_AW, 5, register-address width.
- FWD_STAGES, 2, number of stages after EX that can forward (1 = MEM, 2 = WB, ...); scoreboard depth = FWD_STAGES+1.
- LOAD_STAGE, 2, stage index at which load data first becomes forwardable; legal range 1..FWD_STAGES.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_use_rs, id_use_rt  in  1  each source is actually read.
- id_dst  in  REG_AW  ID destination (after RegDst select).
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze IF/ID.
- id_bubble  out  1  select zero control signals into ID/EX.
- flush_ifid  out  1  clear IF/ID at next edge.
- fwd_sel_a, fwd_sel_b  out  clog2(FWD_STAGES+1)  EX operand A/B source: 0 = ID/EX register value, k = stage k.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Scoreboard entries e[0..FWD_STAGES], e[0] = EX. Each entry holds {valid, rs, rt, use_rs, use_rt, dst, regwrite, load}.
- Each edge: e[k] <= e[k-1] for k >= 1. e[0] <= ID fields when id_valid & !stall & !flush; otherwise e[0].valid <= 0. The scoreboard never freezes, because the pipeline behind ID always advances.
- Producer match, stage k, source s: e[k].valid & e[k].regwrite & e[k].dst == s & s != 0.
- Load-use stall (combinational):
  - stall = id_valid & !ex_branch_taken & (any (id_use_rs, id_rs) or (id_use_rt, id_rt) producer match at an entry j with e[j].load and j < LOAD_STAGE-1).
  - Default parameters: stall only on a load sitting in EX. A dependent load two ahead needs no stall.
  - With LOAD_STAGE=1, stall is never asserted.
- Outputs during stall: pc_hold = ifid_hold = id_bubble = 1. The ID instruction is re-evaluated next cycle and the stall repeats as needed.
- Flush (combinational): flush = ex_branch_taken.
  - flush_ifid = 1 and id_bubble = 1.
  - pc_hold = ifid_hold = 0, so the branch target loads.
  - Flush has priority over stall in the same cycle.
  - The branch in e[0] itself still advances.
- Forwarding (combinational, from registered scoreboard):
  - For e[0].rs when e[0].use_rs & e[0].valid: fwd_sel_a = smallest k in 1..FWD_STAGES with a producer match and (!e[k].load or k >= LOAD_STAGE); else 0. Youngest producer wins.
  - fwd_sel_b likewise for rt.
  - Register 0 is never forwarded.
- Counters:
  - stall_count += 1 on every cycle stall is high; flush_count += 1 on every cycle flush is high.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset, asynchronous, any time including mid-stall:
  - All entries invalid; both counters 0.
  - Hence stall, pc_hold, ifid_hold, id_bubble, flush_ifid and fwd_sel_a/b all read 0 while rst_n is low, except flush_ifid and id_bubble, which follow ex_branch_taken combinationally.
  - No stall resumes after rst_n rises.
- Register-file writes occur in the first half-cycle. The last stage (k = FWD_STAGES) forwards regardless, with no special casing.

Test Plan:
- Reset: hold rst_n=0 with id_valid=1 and a dependent load pattern -> all holds and fwd_sel values 0; counters 0.
- Back-to-back ALU: add $3 issued, next cycle sub uses rs=$3 -> in the sub's EX cycle fwd_sel_a=1. One cycle later, with an unrelated instruction in EX reading $3, fwd_sel_a=2.
- Double producer: $5 written by two consecutive instructions, third reads rt=$5 -> fwd_sel_b=1 (younger wins), not 2.
- Load-use: lw $2 then add rs=$2 -> exactly one cycle of pc_hold=ifid_hold=id_bubble=1, stall_count=1. The add then reaches EX with fwd_sel_a=2.
- Flush beats stall: ex_branch_taken=1 in the same cycle a load-use condition exists -> flush_ifid=1, id_bubble=1, pc_hold=0, stall_count unchanged, flush_count=1.
- Zero register and saturation: producer dst=$0 feeding rs=$0 -> fwd_sel_a=0. With CNT_W=4, 20 consecutive stall cycles -> stall_count=15.
